// File: rtl/execute_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// execute_hazard_ctrl_if
//   Bundles the pipeline-side hazard inputs, the coprocessor LWCP handshake and
//   the controller outputs of the EXECUTE hazard controller.
//   master : pipeline / coprocessor side (drives the hazard inputs, CP_ACK, CP_RDATA)
//   slave  : execute_hazard_ctrl (drives the forwarding selects, stalls, CP_REQ, LWCP results)
// ----------------------------------------------------------------------------
interface execute_hazard_ctrl_if;
    logic [4:0]  ID_EX_RS1;
    logic [4:0]  ID_EX_RS2;
    logic        ID_EX_USES_RS1;
    logic        ID_EX_USES_RS2;
    logic [4:0]  EX_MEM_RD;
    logic        EX_MEM_REG_WRITE;
    logic        EX_MEM_MEM_READ;
    logic        EX_MEM_LWCP;
    logic [4:0]  MEM_WB_RD;
    logic        MEM_WB_REG_WRITE;
    logic        CP_ACK;
    logic [31:0] CP_RDATA;
    logic [1:0]  FORWARD_EXECUTE_A;
    logic [1:0]  FORWARD_EXECUTE_B;
    logic        LOAD_USE_STALL;
    logic        LWCP_STALL;
    logic        CP_REQ;
    logic        LWCP_VALID;
    logic [31:0] LWCP_DATA;
    logic        LWCP_TIMEOUT;

    modport master (
        output ID_EX_RS1, ID_EX_RS2, ID_EX_USES_RS1, ID_EX_USES_RS2,
               EX_MEM_RD, EX_MEM_REG_WRITE, EX_MEM_MEM_READ, EX_MEM_LWCP,
               MEM_WB_RD, MEM_WB_REG_WRITE, CP_ACK, CP_RDATA,
        input  FORWARD_EXECUTE_A, FORWARD_EXECUTE_B, LOAD_USE_STALL, LWCP_STALL,
               CP_REQ, LWCP_VALID, LWCP_DATA, LWCP_TIMEOUT
    );

    modport slave (
        input  ID_EX_RS1, ID_EX_RS2, ID_EX_USES_RS1, ID_EX_USES_RS2,
               EX_MEM_RD, EX_MEM_REG_WRITE, EX_MEM_MEM_READ, EX_MEM_LWCP,
               MEM_WB_RD, MEM_WB_REG_WRITE, CP_ACK, CP_RDATA,
        output FORWARD_EXECUTE_A, FORWARD_EXECUTE_B, LOAD_USE_STALL, LWCP_STALL,
               CP_REQ, LWCP_VALID, LWCP_DATA, LWCP_TIMEOUT
    );
endinterface

// File: rtl/execute_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// execute_hazard_ctrl
//   Hazard and sequencing controller for the EXECUTE stage.
//   - Forwarding selects for operands A/B (10 = from EX_MEM, 01 = from MEM_WB).
//   - Load-use stall when a load in MEM feeds the instruction in EX.
//   - LWCP handshake FSM (IDLE -> WAIT -> DONE) that freezes the whole pipeline
//     through LWCP_STALL while the coprocessor is asked for data, with a
//     timeout that returns zero data and raises a sticky error flag.
//   Ports: clk, rst (async, active high), hz (execute_hazard_ctrl_if.slave).
// ----------------------------------------------------------------------------
module execute_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    execute_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cp_req_q, cp_req_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic              tmo_q, tmo_d;
    logic              lwcp_stall;
    logic              load_use;

    // EX_MEM wins over MEM_WB; a load in EX_MEM cannot forward (its data is
    // not ready yet), which is what the load-use stall covers.
    function automatic logic [1:0] fwd_sel(
        input logic       uses,
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_wr,
        input logic       ex_rd_mem,
        input logic [4:0] wb_rd,
        input logic       wb_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && ex_wr && !ex_rd_mem && (ex_rd != 5'd0) && (ex_rd == rs))
            sel = 2'b10;
        else if (uses && wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign hz.FORWARD_EXECUTE_A = fwd_sel(hz.ID_EX_USES_RS1, hz.ID_EX_RS1,
                                          hz.EX_MEM_RD, hz.EX_MEM_REG_WRITE, hz.EX_MEM_MEM_READ,
                                          hz.MEM_WB_RD, hz.MEM_WB_REG_WRITE);
    assign hz.FORWARD_EXECUTE_B = fwd_sel(hz.ID_EX_USES_RS2, hz.ID_EX_RS2,
                                          hz.EX_MEM_RD, hz.EX_MEM_REG_WRITE, hz.EX_MEM_MEM_READ,
                                          hz.MEM_WB_RD, hz.MEM_WB_REG_WRITE);

    always_comb begin
        load_use = 1'b0;
        if (hz.EX_MEM_MEM_READ && hz.EX_MEM_REG_WRITE && (hz.EX_MEM_RD != 5'd0))
            load_use = (hz.ID_EX_USES_RS1 && (hz.ID_EX_RS1 == hz.EX_MEM_RD)) ||
                       (hz.ID_EX_USES_RS2 && (hz.ID_EX_RS2 == hz.EX_MEM_RD));
    end

    // Stall starts combinationally in the cycle the LWCP reaches MEM and drops
    // in DONE so the pipeline advances exactly once past the LWCP.
    assign lwcp_stall = ((state_q == S_IDLE) && hz.EX_MEM_LWCP) || (state_q == S_WAIT);

    // The global freeze overrides the local bubble insertion.
    assign hz.LOAD_USE_STALL = load_use && !lwcp_stall;
    assign hz.LWCP_STALL     = lwcp_stall;
    assign hz.CP_REQ         = cp_req_q;
    assign hz.LWCP_VALID     = valid_q;
    assign hz.LWCP_DATA      = data_q;
    assign hz.LWCP_TIMEOUT   = tmo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cp_req_d = cp_req_q;
        data_d   = data_q;
        tmo_d    = tmo_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hz.EX_MEM_LWCP) begin
                    state_d  = S_WAIT;
                    cp_req_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_WAIT: begin
                // ACK is checked first so an ACK on the last allowed cycle
                // still delivers data without flagging a timeout.
                if (hz.CP_ACK) begin
                    data_d   = hz.CP_RDATA;
                    cp_req_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d   = '0;
                    tmo_d    = 1'b1;
                    cp_req_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cp_req_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cp_req_q <= cp_req_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_execute_hazard_ctrl
//   Self-checking bench for execute_hazard_ctrl (TIMEOUT_CYCLES = 4).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge. LWCP expectations come from a per-transaction timeline:
//   cycle 0 = LWCP first seen in IDLE, WAIT cycles 1..T, DONE one cycle after
//   the accepted ACK (or after cycle T when none arrives).
// ----------------------------------------------------------------------------
module tb_execute_hazard_ctrl;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   tmo_exp;

    execute_hazard_ctrl_if bus();

    execute_hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.ID_EX_RS1 = '0;        bus.ID_EX_RS2 = '0;
        bus.ID_EX_USES_RS1 = 1'b0; bus.ID_EX_USES_RS2 = 1'b0;
        bus.EX_MEM_RD = '0;        bus.EX_MEM_REG_WRITE = 1'b0;
        bus.EX_MEM_MEM_READ = 1'b0; bus.EX_MEM_LWCP = 1'b0;
        bus.MEM_WB_RD = '0;        bus.MEM_WB_REG_WRITE = 1'b0;
        bus.CP_ACK = 1'b0;         bus.CP_RDATA = '0;
    endtask

    // Reference rules for forwarding and load-use, taken straight from the
    // operand/producer relationships.
    function automatic logic [1:0] m_fwd(input logic uses, input logic [4:0] rs);
        if (!uses) return 2'b00;
        if (bus.EX_MEM_REG_WRITE && !bus.EX_MEM_MEM_READ && bus.EX_MEM_RD != 0 && bus.EX_MEM_RD == rs)
            return 2'b10;
        if (bus.MEM_WB_REG_WRITE && bus.MEM_WB_RD != 0 && bus.MEM_WB_RD == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        bit hit1, hit2;
        hit1 = bus.ID_EX_USES_RS1 && bus.ID_EX_RS1 == bus.EX_MEM_RD;
        hit2 = bus.ID_EX_USES_RS2 && bus.ID_EX_RS2 == bus.EX_MEM_RD;
        return bus.EX_MEM_MEM_READ && bus.EX_MEM_REG_WRITE && bus.EX_MEM_RD != 0 && (hit1 || hit2);
    endfunction

    task automatic test_reset();
        logic [41:0] got;
        rst = 1'b1;
        clr_inputs();
        #2;
        got = {bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B, bus.LOAD_USE_STALL, bus.LWCP_STALL,
               bus.CP_REQ, bus.LWCP_VALID, bus.LWCP_DATA, bus.LWCP_TIMEOUT};
        n_cmp++;
        if (got !== 42'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", got);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tmo_exp = 1'b0;
    endtask

    task automatic test_no_hazard();
        step();
        clr_inputs();
        bus.ID_EX_RS1 = 5'd3; bus.ID_EX_RS2 = 5'd4;
        bus.ID_EX_USES_RS1 = 1'b1; bus.ID_EX_USES_RS2 = 1'b1;
        bus.EX_MEM_RD = 5'd5; bus.EX_MEM_REG_WRITE = 1'b1;
        bus.MEM_WB_RD = 5'd6; bus.MEM_WB_REG_WRITE = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B, bus.LOAD_USE_STALL, bus.LWCP_STALL} !== 6'b0) begin
            n_err++;
            $display("FAIL no_hazard: got %b want 000000",
                     {bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B, bus.LOAD_USE_STALL, bus.LWCP_STALL});
        end
    endtask

    task automatic test_double_match();
        step();
        clr_inputs();
        bus.ID_EX_RS1 = 5'd7; bus.ID_EX_RS2 = 5'd7;
        bus.ID_EX_USES_RS1 = 1'b1; bus.ID_EX_USES_RS2 = 1'b1;
        bus.EX_MEM_RD = 5'd7; bus.EX_MEM_REG_WRITE = 1'b1;
        bus.MEM_WB_RD = 5'd7; bus.MEM_WB_REG_WRITE = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B} !== 4'b1010) begin
            n_err++;
            $display("FAIL double_match_ex: got %b want 1010", {bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B});
        end
        step();
        bus.EX_MEM_RD = 5'd0;
        @(negedge clk);
        n_cmp++;
        if ({bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B} !== 4'b0101) begin
            n_err++;
            $display("FAIL double_match_rd0: got %b want 0101", {bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B});
        end
    endtask

    task automatic test_load_use();
        step();
        clr_inputs();
        bus.EX_MEM_MEM_READ = 1'b1; bus.EX_MEM_REG_WRITE = 1'b1; bus.EX_MEM_RD = 5'd9;
        bus.ID_EX_RS2 = 5'd9; bus.ID_EX_USES_RS2 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.LOAD_USE_STALL, bus.FORWARD_EXECUTE_B} !== 3'b100) begin
            n_err++;
            $display("FAIL load_use_stall: got %b want 100", {bus.LOAD_USE_STALL, bus.FORWARD_EXECUTE_B});
        end
        // bubble sits in EX_MEM, the load moved to MEM_WB
        step();
        bus.EX_MEM_MEM_READ = 1'b0; bus.EX_MEM_REG_WRITE = 1'b0; bus.EX_MEM_RD = 5'd0;
        bus.MEM_WB_RD = 5'd9; bus.MEM_WB_REG_WRITE = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.LOAD_USE_STALL, bus.FORWARD_EXECUTE_B} !== 3'b001) begin
            n_err++;
            $display("FAIL load_use_after: got %b want 001", {bus.LOAD_USE_STALL, bus.FORWARD_EXECUTE_B});
        end
    endtask

    task automatic test_fwd_random();
        logic [5:0] got, exp;
        for (int i = 0; i < 40; i++) begin
            step();
            clr_inputs();
            bus.ID_EX_RS1 = 5'($urandom_range(0, 3));
            bus.ID_EX_RS2 = 5'($urandom_range(0, 3));
            bus.ID_EX_USES_RS1 = 1'($urandom);
            bus.ID_EX_USES_RS2 = 1'($urandom);
            bus.EX_MEM_RD = 5'($urandom_range(0, 3));
            bus.EX_MEM_REG_WRITE = 1'($urandom);
            bus.EX_MEM_MEM_READ = 1'($urandom);
            bus.MEM_WB_RD = 5'($urandom_range(0, 3));
            bus.MEM_WB_REG_WRITE = 1'($urandom);
            @(negedge clk);
            got = {bus.FORWARD_EXECUTE_A, bus.FORWARD_EXECUTE_B, bus.LOAD_USE_STALL, bus.LWCP_STALL};
            exp = {m_fwd(bus.ID_EX_USES_RS1, bus.ID_EX_RS1), m_fwd(bus.ID_EX_USES_RS2, bus.ID_EX_RS2),
                   m_lu(), 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL fwd_random[%0d]: got %b want %b", i, got, exp);
            end
        end
    endtask

    // One LWCP transaction; ack_at is the cycle CP_ACK carries the data
    // (0 = only while IDLE, > T = never inside WAIT). EX_MEM_LWCP is left
    // high afterwards so a following call forms a back-to-back request.
    task automatic lwcp_txn(input int ack_at, input bit lu, input string tag);
        logic [31:0] d;
        logic [6:0]  got, exp;
        bit          hit;
        bit          stall;
        int          end_c;
        d     = $urandom;
        hit   = (ack_at >= 1) && (ack_at <= T);
        end_c = hit ? ack_at + 1 : T + 1;
        for (int c = 0; c <= end_c; c++) begin
            step();
            if (c == 0) begin
                clr_inputs();
                bus.EX_MEM_LWCP = 1'b1;
                if (lu) begin
                    bus.EX_MEM_MEM_READ = 1'b1; bus.EX_MEM_REG_WRITE = 1'b1; bus.EX_MEM_RD = 5'd9;
                    bus.ID_EX_RS2 = 5'd9; bus.ID_EX_USES_RS2 = 1'b1;
                end
            end
            // stray ACKs in IDLE and DONE must be ignored
            bus.CP_ACK   = (c == ack_at) || ((c == 0 || c == end_c) && $urandom_range(0, 1) == 1);
            bus.CP_RDATA = (c == ack_at) ? d : $urandom;
            @(negedge clk);
            stall = (c < end_c);
            if (c == end_c && !hit) tmo_exp = 1'b1;
            got = {bus.LWCP_STALL, bus.CP_REQ, bus.LWCP_VALID, bus.LOAD_USE_STALL,
                   bus.FORWARD_EXECUTE_B, bus.LWCP_TIMEOUT};
            exp = {stall, (c >= 1) && stall, c == end_c, m_lu() && !stall,
                   m_fwd(bus.ID_EX_USES_RS2, bus.ID_EX_RS2), tmo_exp};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s cycle%0d stall/req/valid/lus/fwdB/tmo: got %b want %b", tag, c, got, exp);
            end
            if (c == end_c) begin
                n_cmp++;
                if (bus.LWCP_DATA !== (hit ? d : 32'd0)) begin
                    n_err++;
                    $display("FAIL %s data: got %h want %h", tag, bus.LWCP_DATA, hit ? d : 32'd0);
                end
            end
        end
    endtask

    task automatic lwcp_idle(input string tag);
        step();
        clr_inputs();
        @(negedge clk);
        n_cmp++;
        if ({bus.LWCP_STALL, bus.CP_REQ, bus.LWCP_VALID, bus.LWCP_TIMEOUT} !== {3'b000, tmo_exp}) begin
            n_err++;
            $display("FAIL %s idle: got %b want %b", tag,
                     {bus.LWCP_STALL, bus.CP_REQ, bus.LWCP_VALID, bus.LWCP_TIMEOUT}, {3'b000, tmo_exp});
        end
    endtask

    task automatic test_lwcp_normal();
        lwcp_txn(3, 1'b0, "lwcp_ack3");
        lwcp_idle("lwcp_ack3");
        lwcp_txn(1, 1'b0, "lwcp_ack1");
        lwcp_idle("lwcp_ack1");
        lwcp_txn(T, 1'b0, "lwcp_ack_last");
        lwcp_idle("lwcp_ack_last");
    endtask

    task automatic test_lwcp_timeout();
        lwcp_txn(T + 2, 1'b0, "lwcp_timeout");
        lwcp_idle("lwcp_timeout");
        lwcp_txn(0, 1'b1, "lwcp_timeout_lu");
        lwcp_idle("lwcp_timeout_lu");
        lwcp_txn(2, 1'b1, "lwcp_sticky");
        lwcp_idle("lwcp_sticky");
    endtask

    task automatic test_back_to_back();
        lwcp_txn(2, 1'b0, "b2b_first");
        lwcp_txn(1, 1'b0, "b2b_second");
        lwcp_idle("b2b");
    endtask

    task automatic test_lwcp_random();
        for (int i = 0; i < 10; i++) begin
            lwcp_txn($urandom_range(0, T + 2), 1'($urandom), "lwcp_random");
            if ($urandom_range(0, 1) == 1) lwcp_idle("lwcp_random");
        end
        lwcp_idle("lwcp_random_end");
    endtask

    task automatic test_reset_mid_wait();
        step();
        clr_inputs();
        bus.EX_MEM_LWCP = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        bus.EX_MEM_LWCP = 1'b0;
        #1;
        n_cmp++;
        if ({bus.CP_REQ, bus.LWCP_STALL, bus.LWCP_VALID} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_wait_async: got %b want 000", {bus.CP_REQ, bus.LWCP_STALL, bus.LWCP_VALID});
        end
        tmo_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < T + 3; c++) begin
            step();
            @(negedge clk);
            n_cmp++;
            if ({bus.LWCP_STALL, bus.CP_REQ, bus.LWCP_VALID, bus.LWCP_TIMEOUT} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_mid_wait_after[%0d]: got %b want 0000", c,
                         {bus.LWCP_STALL, bus.CP_REQ, bus.LWCP_VALID, bus.LWCP_TIMEOUT});
            end
        end
        // FSM must accept a fresh request from IDLE after the abort
        lwcp_txn(1, 1'b0, "post_reset");
        lwcp_idle("post_reset");
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_double_match();
        test_load_use();
        test_fwd_random();
        test_lwcp_normal();
        test_lwcp_timeout();
        test_back_to_back();
        test_lwcp_random();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/execute_hazard_ctrl.md
Name: execute_hazard_ctrl

Overview:
- Hazard and sequencing controller for the EXECUTE pipeline stage.
- Generates the forwarding-mux selects (FORWARD_EXECUTE_A/B) and the load-use stall.
- Runs the LWCP (load-word-from-coprocessor) handshake FSM that drives the global LWCP_STALL, which freezes all pipeline registers, and returns coprocessor read data for write-back.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT cycles without CP_ACK before aborting the LWCP.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  global clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_EX_RS1  input  5  source reg 1 address of the instruction in EX.
- ID_EX_RS2  input  5  source reg 2 address of the instruction in EX.
- ID_EX_USES_RS1  input  1  EX instruction reads RS1.
- ID_EX_USES_RS2  input  1  EX instruction reads RS2.
- EX_MEM_RD  input  5  destination of the instruction in MEM.
- EX_MEM_REG_WRITE  input  1  MEM instruction writes the reg file.
- EX_MEM_MEM_READ  input  1  MEM instruction is a load.
- EX_MEM_LWCP  input  1  MEM instruction is an LWCP.
- MEM_WB_RD  input  5  destination of the instruction in WB.
- MEM_WB_REG_WRITE  input  1  WB instruction writes the reg file.
- CP_ACK  input  1  coprocessor data-valid acknowledge.
- CP_RDATA  input  32  coprocessor read data.
- FORWARD_EXECUTE_A  output  2  forwarding select for operand A.
- FORWARD_EXECUTE_B  output  2  forwarding select for operand B.
- LOAD_USE_STALL  output  1  hold IF/ID/EX; insert bubble into EX_MEM.
- LWCP_STALL  output  1  global pipeline freeze.
- CP_REQ  output  1  registered request to the coprocessor.
- LWCP_VALID  output  1  one-cycle pulse; LWCP_DATA is valid.
- LWCP_DATA  output  32  captured coprocessor data (0 on timeout).
- LWCP_TIMEOUT  output  1  sticky error flag.

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, CP_REQ=0, LWCP_VALID=0, LWCP_DATA=0, LWCP_TIMEOUT=0. Combinational outputs evaluate to 0 because state is IDLE.
- Reset mid-operation aborts any LWCP. CP_REQ drops asynchronously. No VALID pulse is generated.
- Forwarding (combinational), per operand X in {RS1→A, RS2→B}:
  - 2'b10 (EX-to-EX) if USES_X, EX_MEM_REG_WRITE, !EX_MEM_MEM_READ, EX_MEM_RD!=0 and EX_MEM_RD==X.
  - Else 2'b01 (MEM-to-EX) if USES_X, MEM_WB_REG_WRITE, MEM_WB_RD!=0 and MEM_WB_RD==X.
  - Else 2'b00.
  - Value 2'b11 is never driven.
  - The EX_MEM match has priority over MEM_WB.
- Load-use (combinational): LOAD_USE_STALL=1 when EX_MEM_MEM_READ, EX_MEM_REG_WRITE, EX_MEM_RD!=0, and EX_MEM_RD matches a used RS1/RS2. It is masked to 0 whenever LWCP_STALL=1.
  - After the one-cycle bubble the load sits in MEM_WB and the operand selects 2'b01.
- LWCP FSM states: IDLE, WAIT, DONE.
  - IDLE: if EX_MEM_LWCP=1, go to WAIT and set CP_REQ<=1 and counter<=0.
  - WAIT: CP_REQ held 1.
    - If CP_ACK: LWCP_DATA<=CP_RDATA, CP_REQ<=0, go to DONE.
    - Else if counter==TIMEOUT_CYCLES-1: LWCP_DATA<=0, LWCP_TIMEOUT<=1, CP_REQ<=0, go to DONE.
    - Else counter increments.
    - An ACK on the final timeout cycle wins: data is captured and no error is flagged.
  - DONE: LWCP_VALID=1 (registered, exactly one cycle). Go to IDLE unconditionally.
  - CP_ACK is ignored outside WAIT.
- LWCP_STALL (combinational) = (IDLE and EX_MEM_LWCP) or WAIT. It is 0 in DONE so the pipeline advances exactly one step.
  - A back-to-back LWCP then re-enters WAIT from IDLE on the next instruction, with a minimum 1 IDLE cycle between requests.
- Latency:
  - Best case, ACK on the first WAIT cycle: the stall lasts 2 cycles and LWCP_VALID pulses 2 cycles after EX_MEM_LWCP is first seen.
  - Timeout case: the stall lasts TIMEOUT_CYCLES+1 cycles.
- LWCP_TIMEOUT clears only on rst.
- Forwarding outputs stay live during LWCP_STALL; the pipeline is frozen, so they are stable.

Test Plan:
- No hazard: RS1=3, RS2=4, EX_MEM_RD=5, MEM_WB_RD=6 -> FORWARD A/B=00, both stalls 0.
- Double match: RS1=RS2=7, EX_MEM_RD=7, EX_MEM_REG_WRITE=1, MEM_WB_RD=7, MEM_WB_REG_WRITE=1 -> A=B=10. Set EX_MEM_RD=0 -> A=B=01.
- Load-use: EX_MEM_MEM_READ=1, EX_MEM_RD=9, RS2=9, USES_RS2=1 -> LOAD_USE_STALL=1, B=00. Next cycle MEM_WB_RD=9 -> B=01, stall 0.
- LWCP normal: EX_MEM_LWCP=1 at cycle 0, CP_ACK=1 with CP_RDATA=0xDEADBEEF at cycle 3:
  - LWCP_STALL=1 cycles 0-3.
  - CP_REQ=1 cycles 1-3.
  - LWCP_VALID=1 at cycle 4 with LWCP_DATA=0xDEADBEEF.
  - LWCP_STALL=0 at cycle 4.
- LWCP timeout with TIMEOUT_CYCLES=4 and no ACK -> CP_REQ high 4 cycles, then LWCP_VALID=1, LWCP_DATA=0, LWCP_TIMEOUT=1 and stays set. Repeat with simultaneous load-use -> LOAD_USE_STALL masked to 0.
- Reset mid-WAIT: assert rst 2 cycles into WAIT -> CP_REQ and LWCP_STALL drop before the next clk edge, no LWCP_VALID pulse, and the FSM is in IDLE after release.
